// File: rtl/efpga_mae_param.sv
// Parametrised DSP-column multiply-accumulate element: P = A*B, A*B+C, or P+A*B.
// Define MAE_SATURATE_EN to clamp P on post-adder overflow instead of wrapping.
module efpga_mae_param #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int P_WIDTH   = 40,
  parameter int REG_IN    = 1,
  parameter int REG_P     = 1,
  parameter int POST_MODE = 0,
  parameter int SIGNED    = 1
) (
  input  logic               CLK,
  input  logic               ARST_N,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic [P_WIDTH-1:0] C,
  input  logic               A_EN,
  input  logic               B_EN,
  input  logic               C_EN,
  input  logic               A_SRST_N,
  input  logic               B_SRST_N,
  input  logic               C_SRST_N,
  input  logic               P_EN,
  input  logic               P_SRST_N,
  input  logic               ACC_LOAD,
  input  logic               IN_VALID,
  output logic               OUT_VALID,
  output logic [P_WIDTH-1:0] P,
  output logic               OVF
);

  localparam int PRW = A_WIDTH + B_WIDTH;

  if (P_WIDTH < PRW) begin : g_bad_pw
    $error("P_WIDTH must be >= A_WIDTH + B_WIDTH");
  end
  if (POST_MODE == 2 && REG_P != 1) begin : g_bad_acc
    $error("POST_MODE=2 needs REG_P=1");
  end
  if (A_WIDTH < 2 || A_WIDTH > 27 || B_WIDTH < 2 || B_WIDTH > 27) begin : g_bad_w
    $error("A_WIDTH/B_WIDTH must be 2..27");
  end

  logic [A_WIDTH-1:0] a_q, a_s;
  logic [B_WIDTH-1:0] b_q, b_s;
  logic [P_WIDTH-1:0] c_q, c_s;
  logic               v1_q, v1_s;

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      a_q  <= '0;
      v1_q <= 1'b0;
    end else if (!A_SRST_N) begin
      a_q  <= '0;
      v1_q <= 1'b0;
    end else if (A_EN) begin
      a_q  <= A;
      v1_q <= IN_VALID;
    end
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N)        b_q <= '0;
    else if (!B_SRST_N) b_q <= '0;
    else if (B_EN)      b_q <= B;
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N)        c_q <= '0;
    else if (!C_SRST_N) c_q <= '0;
    else if (C_EN)      c_q <= C;
  end

  // Absent input stage collapses to wires; the unused regs are trimmed.
  assign a_s  = (REG_IN != 0) ? a_q  : A;
  assign b_s  = (REG_IN != 0) ? b_q  : B;
  assign c_s  = (REG_IN != 0) ? c_q  : C;
  assign v1_s = (REG_IN != 0) ? v1_q : IN_VALID;

  logic [PRW-1:0]     a_x, b_x, prod;
  logic [P_WIDTH-1:0] prod_x, add_x, sum, res_d;
  logic [P_WIDTH:0]   sum_w;
  logic               ovf_add, ovf_d;
  logic [P_WIDTH-1:0] p_q;
  logic               ovf_q, vo_q;

  always_comb begin
    if (SIGNED != 0) begin
      a_x = PRW'($signed(a_s));
      b_x = PRW'($signed(b_s));
    end else begin
      a_x = PRW'(a_s);
      b_x = PRW'(b_s);
    end
    prod = a_x * b_x;
    if (SIGNED != 0) prod_x = P_WIDTH'($signed(prod));
    else             prod_x = P_WIDTH'(prod);
  end

  always_comb begin
    add_x = '0;
    if (POST_MODE == 1)      add_x = c_s;
    else if (POST_MODE == 2) add_x = ACC_LOAD ? c_s : p_q;
    sum_w = {1'b0, add_x} + {1'b0, prod_x};
    sum   = sum_w[P_WIDTH-1:0];
    if (POST_MODE == 0) ovf_add = 1'b0;
    else if (SIGNED != 0)
      ovf_add = (add_x[P_WIDTH-1] == prod_x[P_WIDTH-1]) &&
                (sum[P_WIDTH-1] != add_x[P_WIDTH-1]);
    else ovf_add = sum_w[P_WIDTH];
    res_d = sum;
`ifdef MAE_SATURATE_EN
    // Signed overflow direction follows the shared operand sign.
    if (ovf_add) begin
      if (SIGNED == 0)           res_d = '1;
      else if (add_x[P_WIDTH-1]) res_d = {1'b1, {(P_WIDTH-1){1'b0}}};
      else                       res_d = {1'b0, {(P_WIDTH-1){1'b1}}};
    end
`endif
    ovf_d = ((POST_MODE == 2) && ACC_LOAD) ? ovf_add : (ovf_q | ovf_add);
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      p_q   <= '0;
      ovf_q <= 1'b0;
      vo_q  <= 1'b0;
    end else if (!P_SRST_N) begin
      p_q   <= '0;
      ovf_q <= 1'b0;
      vo_q  <= 1'b0;
    end else if (P_EN) begin
      p_q   <= res_d;
      ovf_q <= ovf_d;
      vo_q  <= v1_s;
    end
  end

  assign P         = (REG_P != 0) ? p_q   : res_d;
  assign OVF       = (REG_P != 0) ? ovf_q : ovf_add;
  assign OUT_VALID = (REG_P != 0) ? vo_q  : v1_s;

endmodule

// File: tb/tb_efpga_mae_param.sv
// Bench for efpga_mae_param: three registered instances (modes 0/1/2, signed)
// plus one combinational unsigned mode-1 instance, checked against an arithmetic model.
module tb_efpga_mae_param;

  logic        CLK = 1'b0;
  logic        ARST_N;
  logic [17:0] A, B;
  logic [39:0] C;
  logic        A_EN, B_EN, C_EN, A_SRST_N, B_SRST_N, C_SRST_N;
  logic        P_EN, P_SRST_N, ACC_LOAD, IN_VALID;
  logic [39:0] p   [4];
  logic        ov  [4];
  logic        ovf [4];

  int vec = 0;
  int bad = 0;
  bit run = 1'b0;

  always #5 CLK = ~CLK;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    efpga_mae_param #(
      .REG_IN   (k == 3 ? 0 : 1),
      .REG_P    (k == 3 ? 0 : 1),
      .POST_MODE(k == 3 ? 1 : k),
      .SIGNED   (k == 3 ? 0 : 1)
    ) u (
      .CLK(CLK), .ARST_N(ARST_N),
      .A(A), .B(B), .C(C),
      .A_EN(A_EN), .B_EN(B_EN), .C_EN(C_EN),
      .A_SRST_N(A_SRST_N), .B_SRST_N(B_SRST_N), .C_SRST_N(C_SRST_N),
      .P_EN(P_EN), .P_SRST_N(P_SRST_N),
      .ACC_LOAD(ACC_LOAD), .IN_VALID(IN_VALID),
      .OUT_VALID(ov[k]), .P(p[k]), .OVF(ovf[k])
    );
  end

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model of a signed registered instance: values held as plain integers.
  typedef struct {
    longint a, b, c;
    bit v;
    logic [39:0] p;
    bit ov, ovf;
  } mdl_t;
  mdl_t m [3];

  localparam longint MX = (64'sd1 <<< 39) - 1;
  localparam longint MN = -(64'sd1 <<< 39);

  function automatic longint sx40(input logic [39:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sx18(input logic [17:0] v);
    return longint'($signed(v));
  endfunction

  function automatic mdl_t nxt(input mdl_t m0, input int md);
    mdl_t n;
    longint x, t;
    bit o;
    logic [39:0] r;
    n = m0;
    x = 0;
    if (md == 1)      x = m0.c;
    else if (md == 2) x = ACC_LOAD ? m0.c : sx40(m0.p);
    t = x + m0.a * m0.b;
    o = (md != 0) && (t > MX || t < MN);
    r = t[39:0];
`ifdef MAE_SATURATE_EN
    if (o) r = (t > 0) ? 40'h7F_FFFF_FFFF : 40'h80_0000_0000;
`endif
    if (!P_SRST_N) begin
      n.p = '0; n.ov = 0; n.ovf = 0;
    end else if (P_EN) begin
      n.p = r;
      n.ov = m0.v;
      n.ovf = (md == 2 && ACC_LOAD) ? o : (m0.ovf | o);
    end
    if (!A_SRST_N) begin
      n.a = 0; n.v = 0;
    end else if (A_EN) begin
      n.a = sx18(A); n.v = IN_VALID;
    end
    if (!B_SRST_N) n.b = 0; else if (B_EN) n.b = sx18(B);
    if (!C_SRST_N) n.c = 0; else if (C_EN) n.c = sx40(C);
    return n;
  endfunction

  always @(posedge CLK or negedge ARST_N) begin
    for (int k = 0; k < 3; k++) begin
      if (!ARST_N) m[k] <= '{a:0, b:0, c:0, v:0, p:'0, ov:0, ovf:0};
      else         m[k] <= nxt(m[k], k);
    end
  end

  always @(negedge CLK) begin
    if (run) begin
      longint t;
      bit o;
      logic [39:0] e;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d P", k), p[k], m[k].p);
        chk($sformatf("u%0d OUT_VALID", k), 40'(ov[k]), 40'(m[k].ov));
        chk($sformatf("u%0d OVF", k), 40'(ovf[k]), 40'(m[k].ovf));
      end
      t = longint'(A) * longint'(B) + longint'(C);
      o = t >= (64'sd1 <<< 40);
      e = t[39:0];
`ifdef MAE_SATURATE_EN
      if (o) e = '1;
`endif
      chk("u3 P", p[3], e);
      chk("u3 OUT_VALID", 40'(ov[3]), 40'(IN_VALID));
      chk("u3 OVF", 40'(ovf[3]), 40'(o));
    end
  end

  task automatic cyc(input longint a, input longint b, input logic [39:0] c, input bit ld);
    A = 18'(a);
    B = 18'(b);
    C = c;
    ACC_LOAD = ld;
    @(posedge CLK);
    #1;
  endtask

`ifdef MAE_SATURATE_EN
  localparam logic [39:0] E_OV1 = 40'h7F_FFFF_FFFF;
  localparam logic [39:0] E_OV2 = 40'h7F_FFFF_FFFF;
  localparam logic [39:0] E_OVU = 40'hFF_FFFF_FFFF;
`else
  localparam logic [39:0] E_OV1 = 40'h83_FFFC_0000;
  localparam logic [39:0] E_OV2 = 40'h80_0000_0010;
  localparam logic [39:0] E_OVU = 40'h0F_FFF8_0000;
`endif

  initial begin
    ARST_N = 1'b0;
    A = '0; B = '0; C = '0;
    A_EN = 1; B_EN = 1; C_EN = 1;
    A_SRST_N = 1; B_SRST_N = 1; C_SRST_N = 1;
    P_EN = 1; P_SRST_N = 1; ACC_LOAD = 0; IN_VALID = 0;
    @(posedge CLK); #1;
    run = 1'b1;
    @(posedge CLK); #1;
    chk("reset u0 P", p[0], 40'h0);
    chk("reset u2 OUT_VALID", 40'(ov[2]), 40'h0);
    chk("reset u1 OVF", 40'(ovf[1]), 40'h0);
    ARST_N = 1'b1;
    IN_VALID = 1'b1;

    cyc(-3, 7, 40'h0, 0);
    chk("lat1 u0 OUT_VALID", 40'(ov[0]), 40'h0);
    cyc(100, 200, 40'd5, 0);
    chk("mul u0 P", p[0], 40'hFF_FFFF_FFEB);
    chk("mul u0 OUT_VALID", 40'(ov[0]), 40'h1);
    cyc(18'h1FFFF, 18'h1FFFF, 40'h7F_FFFF_FFFF, 0);
    chk("addc u1 P", p[1], 40'd20005);
    chk("addc u1 OVF", 40'(ovf[1]), 40'h0);
    cyc(2, 3, 40'd10, 0);
    chk("addc ovf u1 P", p[1], E_OV1);
    chk("addc ovf u1 OVF", 40'(ovf[1]), 40'h1);

    cyc(2, 3, 40'd10, 1);
    chk("acc load u2 P", p[2], 40'd16);
    for (int i = 1; i <= 4; i++) begin
      cyc(2, 3, 40'h0, 0);
      chk($sformatf("acc step%0d u2 P", i), p[2], 40'(16 + 6 * i));
    end

    P_EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(2, 3, 40'h0, 0);
      chk("hold u2 P", p[2], 40'd40);
      chk("hold u2 OUT_VALID", 40'(ov[2]), 40'h1);
    end
    P_EN = 1'b1;
    cyc(2, 3, 40'h0, 0);
    chk("resume u2 P", p[2], 40'd46);
    A_SRST_N = 1'b0;
    cyc(5, 3, 40'h0, 0);
    A_SRST_N = 1'b1;
    cyc(5, 3, 40'h0, 0);
    chk("asrst u0 P", p[0], 40'h0);
    chk("asrst u0 OUT_VALID", 40'(ov[0]), 40'h0);
    chk("asrst u2 P", p[2], 40'd52);
    P_SRST_N = 1'b0;
    cyc(2, 3, 40'd10, 1);
    P_SRST_N = 1'b1;
    chk("psrst+load u2 P", p[2], 40'h0);

    cyc(2, 3, 40'd10, 1);
    cyc(2, 3, 40'h0, 0);
    cyc(2, 3, 40'h0, 0);
    cyc(2, 3, 40'h0, 0);
    chk("pre-arst u2 P", p[2], 40'd34);
    #2 ARST_N = 1'b0;
    #1;
    chk("arst u2 P", p[2], 40'h0);
    chk("arst u2 OUT_VALID", 40'(ov[2]), 40'h0);
    chk("arst u1 OVF", 40'(ovf[1]), 40'h0);
    @(negedge CLK);
    #2 ARST_N = 1'b1;
    cyc(2, 3, 40'h0, 0);
    cyc(2, 3, 40'h0, 0);
    chk("restart u2 P", p[2], 40'd6);

    cyc(0, 0, 40'h7F_FFFF_FFF0, 0);
    cyc(32, 1, 40'h0, 1);
    cyc(32, 1, 40'h0, 0);
    chk("acc ovf u2 P", p[2], E_OV2);
    chk("acc ovf u2 OVF", 40'(ovf[2]), 40'h1);
    cyc(2, 3, 40'd10, 1);
    chk("load clears u2 OVF", 40'(ovf[2]), 40'h0);
    chk("load u2 P", p[2], 40'd32);

    cyc(-131072, -131072, 40'h0, 0);
    cyc(0, 0, 40'h0, 0);
    chk("min*min u0 P", p[0], 40'h04_0000_0000);
    cyc(-1, -1, 40'hFF_FFFF_FFFF, 0);
    chk("unsigned u3 P", p[3], E_OVU);
    chk("unsigned u3 OVF", 40'(ovf[3]), 40'h1);
    cyc(0, 0, 40'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
